// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state encoding, grant IDs and sizing helpers for the memory arbiter
package mem_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, I_BUSY = 2'b01, D_BUSY = 2'b10} arb_state_t;
  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;
  localparam int LATENCY_DEF = 4;
  function automatic int cnt_width(input int lat);
    return lat > 1 ? $clog2(lat) : 1;
  endfunction
endpackage

// File: rtl/mem_lat_counter.sv
// mem_lat_counter: loadable down-counter timing one memory access, flags zero on the last busy cycle
module mem_lat_counter import mem_arbiter_pkg::*; #(
  parameter int LATENCY = LATENCY_DEF,
  localparam int W = cnt_width(LATENCY)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec && !zero) cnt <= cnt - W'(1);
  end
  always_comb zero = cnt == '0;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency memory port between fetch (I) and memory-stage (D) requesters
module mem_arbiter import mem_arbiter_pkg::*; #(
  parameter int LATENCY = LATENCY_DEF,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ireq,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              idone,
  output logic [DATA_W-1:0] irdata,
  input  logic              dreq,
  input  logic              dwr,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dwdata,
  output logic              ddone,
  output logic [DATA_W-1:0] drdata,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int CW = cnt_width(LATENCY);
  localparam logic [CW-1:0] LOAD = CW'(LATENCY - 1);
  arb_state_t state;
  logic last_grant, req_i, req_d, gnt_i, gnt_d, grant, busy, zero;
  // a side's request is ignored in its own done cycle since req is still held then
  always_comb begin
    req_i = ireq & ~idone;
    req_d = dreq & ~ddone;
    gnt_d = state == IDLE && req_d && (!req_i || last_grant == GNT_I);
    gnt_i = state == IDLE && req_i && !gnt_d;
    grant = gnt_i | gnt_d;
    busy = state != IDLE;
    stall_if = ireq & ~idone;
    stall_mem = dreq & ~ddone;
  end
  mem_lat_counter #(.LATENCY(LATENCY)) u_cnt (
    .clk(clk),
    .rst(rst),
    .load(grant),
    .load_val(LOAD),
    .dec(busy),
    .zero(zero)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last_grant <= GNT_I;
      mem_en <= 1'b0;
      mem_wr <= 1'b0;
      idone <= 1'b0;
      ddone <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      irdata <= '0;
      drdata <= '0;
    end else begin
      mem_en <= grant;
      idone <= state == I_BUSY && zero;
      ddone <= state == D_BUSY && zero;
      if (grant) begin
        state <= gnt_d ? D_BUSY : I_BUSY;
        last_grant <= gnt_d;
        mem_wr <= gnt_d & dwr;
        mem_addr <= gnt_d ? daddr : iaddr;
        mem_wdata <= gnt_d ? dwdata : '0;
      end else if (busy && zero) state <= IDLE;
      if (state == I_BUSY && zero) irdata <= mem_rdata;
      if (state == D_BUSY && zero && !mem_wr) drdata <= mem_rdata;
    end
  end
endmodule
